// File: rtl/logicnet_input_quantizer.sv
// Streaming 2-bit feature quantizer and sample packer for LogicNet layer 0, double-buffered.
// Optional LOGICNET_QUANT_STATS_EN adds a 32-bit output handshake counter (o_sample_count).
module logicnet_input_quantizer #(
   parameter int NUM_FEATURES = 16,
   parameter int FEAT_WIDTH   = 16,
   localparam int AW = $clog2(3*NUM_FEATURES),
   localparam int IW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic [FEAT_WIDTH-1:0]     i_in_data,
   input  logic                      i_in_last,
   input  logic                      i_cfg_we,
   input  logic [AW-1:0]             i_cfg_addr,
   input  logic [FEAT_WIDTH-1:0]     i_cfg_data,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic [2*NUM_FEATURES-1:0] o_out_data,
`ifdef LOGICNET_QUANT_STATS_EN
   output logic [31:0]               o_sample_count,
`endif
   output logic                      o_err_len
);

   typedef enum logic [1:0] {S_COLLECT, S_HOLD, S_STALL} state_t;

   state_t                         r_state, w_state_nxt;
   logic [IW-1:0]                  r_idx;
   logic [NUM_FEATURES-1:0][1:0]   r_coll, r_out, w_vec;
   logic [FEAT_WIDTH-1:0]          r_thr [NUM_FEATURES][3];
   logic                           r_err;
   logic [2:0]                     w_ge;
   logic [1:0]                     w_code;
   logic                           w_beat, w_at_end, w_done, w_abort, w_take;
   logic                           w_load_new, w_load_pend;

   assign o_in_ready  = (r_state != S_STALL);
   assign o_out_valid = (r_state != S_COLLECT);
   assign o_out_data  = r_out;
   assign o_err_len   = r_err;

   assign w_beat   = i_in_valid & o_in_ready;
   assign w_at_end = (r_idx == IW'(NUM_FEATURES-1));
   assign w_done   = w_beat & w_at_end;
   assign w_abort  = w_beat & i_in_last & ~w_at_end;
   assign w_take   = o_out_valid & i_out_ready;

   // Registered thresholds are read here, so a same-cycle write lands after this beat.
   always_comb begin
      for (int k = 0; k < 3; k++)
         w_ge[k] = (i_in_data >= r_thr[r_idx][k]);
      w_code = 2'(w_ge[0]) + 2'(w_ge[1]) + 2'(w_ge[2]);
      w_vec = r_coll;
      w_vec[r_idx] = w_code;
   end

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < NUM_FEATURES; i++)
         for (int k = 0; k < 3; k++)
            if (i_rst)
               r_thr[i][k] <= FEAT_WIDTH'((k+1) << (FEAT_WIDTH-2));
            else if (i_cfg_we && i_cfg_addr == AW'(3*i+k))
               r_thr[i][k] <= i_cfg_data;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load_new  = 1'b0;
      w_load_pend = 1'b0;
      case (r_state)
         S_COLLECT: if (w_done) begin
            w_state_nxt = S_HOLD;
            w_load_new  = 1'b1;
         end
         S_HOLD: begin
            if (w_done && w_take)  w_load_new  = 1'b1;
            else if (w_done)       w_state_nxt = S_STALL;
            else if (w_take)       w_state_nxt = S_COLLECT;
         end
         S_STALL: if (w_take) begin
            w_state_nxt = S_HOLD;
            w_load_pend = 1'b1;
         end
         default: w_state_nxt = S_COLLECT;
      endcase
   end

   // In STALL the completed sample simply stays in r_coll until the output frees up.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_COLLECT;
         r_idx   <= '0;
         r_coll  <= '0;
         r_out   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_beat) begin
            r_coll <= w_vec;
            r_idx  <= (w_done || w_abort) ? '0 : r_idx + IW'(1);
         end
         if (w_load_new)       r_out <= w_vec;
         else if (w_load_pend) r_out <= r_coll;
         if ((w_done && !i_in_last) || w_abort) r_err <= 1'b1;
      end
   end

`ifdef LOGICNET_QUANT_STATS_EN
   logic [31:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst)       r_cnt <= '0;
      else if (w_take) r_cnt <= r_cnt + 32'd1;
   end
   assign o_sample_count = r_cnt;
`endif

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Directed bench for logicnet_input_quantizer: scoreboard of packed vectors plus a threshold model.
module tb_logicnet_input_quantizer;
   localparam int NF = 4;
   localparam int FW = 8;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_last, cfg_we, out_ready;
   logic [FW-1:0] in_data, cfg_data;
   logic [3:0]    cfg_addr;
   logic          in_ready, out_valid, err_len;
   logic [2*NF-1:0] out_data;
`ifdef LOGICNET_QUANT_STATS_EN
   logic [31:0]   sample_count;
   int            m_cnt;
`endif

   logicnet_input_quantizer #(.NUM_FEATURES(NF), .FEAT_WIDTH(FW)) dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .i_in_last(in_last), .i_cfg_we(cfg_we),
      .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data), .o_out_valid(out_valid),
      .i_out_ready(out_ready), .o_out_data(out_data),
`ifdef LOGICNET_QUANT_STATS_EN
      .o_sample_count(sample_count),
`endif
      .o_err_len(err_len));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [FW-1:0]   m_thr [NF][3];
   int              m_idx;
   logic [2*NF-1:0] m_vec;
   logic            m_err;
   logic [2*NF-1:0] q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NF; i++) begin
         m_thr[i][0] = 8'd64; m_thr[i][1] = 8'd128; m_thr[i][2] = 8'd192;
      end
      m_idx = 0; m_vec = '0; m_err = 1'b0; q.delete();
`ifdef LOGICNET_QUANT_STATS_EN
      m_cnt = 0;
`endif
   endtask

   function automatic logic [1:0] m_code(input int f, input logic [FW-1:0] d);
      int c = 0;
      for (int k = 0; k < 3; k++) if (d >= m_thr[f][k]) c++;
      return 2'(c);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One feature beat, optionally with a concurrent threshold write.
   task automatic beat(input logic [FW-1:0] d, input logic last, input logic we = 1'b0,
                       input logic [3:0] a = 4'd0, input logic [FW-1:0] cd = '0);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      cfg_we = we; cfg_addr = a; cfg_data = cd;
      @(negedge clk);
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      else begin
         m_vec[2*m_idx +: 2] = m_code(m_idx, d);
         if (m_idx == NF-1) begin
            if (!last) m_err = 1'b1;
            q.push_back(m_vec); m_idx = 0;
         end else if (last) begin
            m_err = 1'b1; m_idx = 0;
         end else m_idx++;
      end
      if (we && a < 4'(3*NF)) m_thr[a/3][a%3] = cd;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic sample(input logic [FW-1:0] d0, d1, d2, d3);
      beat(d0, 1'b0); beat(d1, 1'b0); beat(d2, 1'b0); beat(d3, 1'b1);
   endtask

   // Output monitor: every valid vector must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
         else begin
            chk("out_data", 32'(out_data), 32'(q[0]));
            if (out_ready) begin
               void'(q.pop_front());
`ifdef LOGICNET_QUANT_STATS_EN
               m_cnt++;
`endif
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
      m_reset();
      tick(2);
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_err_len", 32'(err_len), 32'd0);

      // basic sample, registered output one cycle after the last beat
      sample(8'd0, 8'd64, 8'd127, 8'd255);
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_data", 32'(out_data), 32'hD4);
      chk("basic_err", 32'(err_len), 32'd0);
      tick(2);

      // backpressure: two samples fill output + collect buffer
      out_ready = 1'b0;
      for (int s = 0; s < 2; s++)
         sample(8'($urandom_range(255)), 8'($urandom_range(255)),
                8'($urandom_range(255)), 8'($urandom_range(255)));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_held_data", 32'(out_data), 32'(q[0]));
      tick(3);
      chk("stall_still_held", 32'(out_data), 32'(q[0]));
      chk("stall_still_blocked", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      sample(8'd200, 8'd10, 8'd150, 8'd90);
      tick(4);
      chk("stall_drained", 32'(q.size()), 32'd0);

      // threshold programming, out-of-range write ignored
      cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 8'd10; tick(1);
      m_thr[1][0] = 8'd10;
      cfg_addr = 4'd13; cfg_data = 8'd0; tick(1);
      cfg_we = 1'b0;
      sample(8'd0, 8'd20, 8'd0, 8'd0);
      chk("cfg_code", 32'(out_data), 32'h04);
      tick(1);
      beat(8'd0, 1'b0); beat(8'd20, 1'b0, 1'b1, 4'd4, 8'd15); beat(8'd0, 1'b0); beat(8'd0, 1'b1);
      chk("cfg_same_cycle_old", 32'(out_data), 32'h04);
      tick(1);
      sample(8'd0, 8'd20, 8'd0, 8'd0);
      chk("cfg_new_applied", 32'(out_data), 32'h08);
      tick(2);

      // early in_last: discarded, sticky error
      beat(8'd5, 1'b0); beat(8'd200, 1'b1);
      chk("early_last_err", 32'(err_len), 32'd1);
      chk("early_last_no_out", 32'(out_valid), 32'd0);
      sample(8'd255, 8'd255, 8'd0, 8'd130);
      chk("after_early_valid", 32'(out_valid), 32'd1);
      tick(2);

      // reset mid-sample
      beat(8'd7, 1'b0); beat(8'd8, 1'b0);
      rst = 1'b1; m_reset(); tick(1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_err", 32'(err_len), 32'd0);
      rst = 1'b0;
      sample(8'd0, 8'd64, 8'd127, 8'd255);
      chk("postrst_defaults", 32'(out_data), 32'hD4);
      tick(2);

      // missing in_last on final beat: delivered, error flagged
      beat(8'd192, 1'b0); beat(8'd191, 1'b0); beat(8'd128, 1'b0); beat(8'd63, 1'b0);
      chk("nolast_valid", 32'(out_valid), 32'd1);
      chk("nolast_err", 32'(err_len), 32'd1);
      tick(2);
      chk("err_model", 32'(err_len), 32'(m_err));

`ifdef LOGICNET_QUANT_STATS_EN
      for (int s = 0; s < 3; s++) sample(8'(s*50), 8'd1, 8'd100, 8'd250);
      tick(2);
      chk("stats_count5", sample_count, 32'd5);
      chk("stats_model", sample_count, 32'(m_cnt));
      rst = 1'b1; m_reset(); tick(1); rst = 1'b0;
      chk("stats_reset", sample_count, 32'd0);
`endif

      chk("final_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      chk("global_timeout", 32'(n_vec), 32'hFFFF_FFFF);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "FAIL global timeout");
   end
endmodule

// File: doc/logicnet_input_quantizer.md
# logicnet_input_quantizer

Streaming front end for the LogicNet classifier: accepts raw feature words one per cycle, quantizes each to a 2-bit code against programmable per-feature thresholds, and packs a full sample into the flat input vector consumed by the layer-0 neuron LUTs. Sits directly upstream of layer 0. It double-buffers so the next sample can be collected while the previous packed vector waits for the network pipeline.

## Interface
- NUM_FEATURES, 16: features per sample; output vector width is 2*NUM_FEATURES.
- FEAT_WIDTH, 16: raw feature width, unsigned.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  raw feature present.
- in_ready  out  1  block can accept a feature this cycle.
- in_data  in  FEAT_WIDTH  raw feature value.
- in_last  in  1  marks final feature of a sample.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  clog2(3*NUM_FEATURES)  threshold index = 3*feature + k, k in 0..2.
- cfg_data  in  FEAT_WIDTH  threshold value.
- out_valid  out  1  packed vector valid.
- out_ready  in  1  layer 0 accepts vector.
- out_data  out  2*NUM_FEATURES  packed codes; feature i at bits [2i+1:2i].
- err_len  out  1  sticky sample-length error.

## Operation
- Code for feature i: count of k in {0,1,2} with in_data >= T[i][k] (unsigned compare); range 0..3. No threshold ordering is enforced; the count rule applies even when the thresholds are non-monotonic.
- Reset thresholds: T[i][k] = (k+1) << (FEAT_WIDTH-2) for all i.
- Collection: feature index counter starts at 0 and increments on each accepted beat (in_valid & in_ready). Each code is written into the collect buffer at its index.
- Sample completion:
  - Completes on the beat where the index equals NUM_FEATURES-1. The collect buffer transfers to the output register, and the index returns to 0.
  - If in_last is low on that beat, err_len is set and the sample is still delivered.
  - If in_last is high on an earlier beat, err_len is set, the partial sample is discarded, and the index returns to 0.
- States:
  - COLLECT: output register empty.
  - HOLD: output register full, collecting the next sample.
  - STALL: output full and collect buffer complete, in_ready=0.
  - COLLECT→HOLD on completion. HOLD→COLLECT on output handshake without a new completion. HOLD→STALL on completion while the output is not taken. STALL→HOLD on output handshake, when the pending buffer moves to output in the same cycle.
- Output handshake: a vector transfers when out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- Config writes:
  - Take effect from the next cycle.
  - A feature accepted in the same cycle as a write to its own threshold uses the old value.
  - cfg_addr >= 3*NUM_FEATURES is ignored.
- err_len clears only on rst.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, err_len=0, index=0, state COLLECT, thresholds at defaults.
- Latency: the vector is registered, so out_valid rises the cycle after the completing beat.
- Throughput: one feature per cycle sustained; no bubble between samples when out_ready=1.
- Simultaneous completion and output handshake in HOLD: the old vector leaves, the new vector loads the same cycle, and out_valid stays 1.
- in_ready is combinational from state only, not from in_valid.
- rst mid-sample discards all buffered data. Thresholds return to their defaults.

## Configuration
- LOGICNET_QUANT_STATS_EN defined: adds output sample_count (32-bit), which increments on each output handshake, wraps at 2^32, and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- NUM_FEATURES=4, FEAT_WIDTH=8, default thresholds 64/128/192. Input 0,64,127,255 with in_last on the 4th beat -> out_data=8'hD4 one cycle after the 4th beat, err_len=0.
- Hold out_ready=0 and stream 3 samples back-to-back: first vector is held stable; second sample completes; in_ready drops after the 8th beat. Raise out_ready -> vectors delivered in order with no loss.
- Write T[1][0]=10 via cfg_addr=3, then send feature 1 value 20 -> code 1 (under the default it would be 0). A same-cycle write and accept uses the old threshold.
- Assert in_last on beat 2 of 4 -> err_len=1, no out_valid. The next full 4-beat sample is delivered correctly.
- Assert rst in the middle of a sample -> out_valid=0 and in_ready=1 next cycle. Thresholds back at 64/128/192; a fresh sample yields the expected codes.
- With LOGICNET_QUANT_STATS_EN defined, 5 output handshakes -> sample_count=5; rst -> 0.
